// File: rtl/imem_loadable.sv
// imem_loadable: instruction memory with registered fetch port, clear-after-reset pass and word-serial program load.
module imem_loadable #(
  parameter int DEPTH = 512,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      Address,
  input  logic             fetch_en,
  output logic [31:0]      Instruction,
  output logic             inst_valid,
  output logic [1:0]       fetch_fault,
  input  logic             load_start,
  input  logic [IDX_W:0]   load_len,
  input  logic [31:0]      load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             load_done,
  output logic             busy
);
  typedef enum logic [1:0] {CLEAR, READY, LOAD} state_t;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);
  localparam logic [IDX_W:0] DEPTH_L = (IDX_W + 1)'(DEPTH);
  logic [31:0] mem [DEPTH];
  state_t state, state_nx;
  logic [IDX_W-1:0] ptr, ptr_nx;
  logic [IDX_W:0] len, len_nx, len_req;
  logic done_nx, we, accept, last_load, misaligned, out_of_range;
  logic [31:0] wdata;
  assign len_req = load_len > DEPTH_L ? DEPTH_L : load_len;
  assign load_ready = state == LOAD;
  assign busy = state != READY;
  assign accept = load_valid & load_ready;
  assign last_load = {1'b0, ptr} == len - 1'b1;
  assign misaligned = |Address[1:0];
  assign out_of_range = |(Address >> (IDX_W + 2));
  always_comb begin
    state_nx = state;
    ptr_nx = ptr;
    len_nx = len;
    done_nx = 1'b0;
    we = 1'b0;
    wdata = load_data;
    case (state)
      CLEAR: begin
        we = 1'b1;
        wdata = '0;
        ptr_nx = ptr + 1'b1;
        state_nx = ptr == LAST ? READY : CLEAR;
      end
      READY: if (load_start) begin
        len_nx = len_req;
        ptr_nx = '0;
        done_nx = len_req == '0;
        state_nx = len_req == '0 ? READY : LOAD;
      end
      LOAD: if (accept) begin
        we = 1'b1;
        ptr_nx = last_load ? '0 : ptr + 1'b1;
        done_nx = last_load;
        state_nx = last_load ? READY : LOAD;
      end
      default: state_nx = CLEAR;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= CLEAR;
      ptr <= '0;
      len <= '0;
      load_done <= 1'b0;
      Instruction <= NOP_WORD;
      inst_valid <= 1'b0;
      fetch_fault <= '0;
    end else begin
      state <= state_nx;
      ptr <= ptr_nx;
      len <= len_nx;
      load_done <= done_nx;
      if (state != READY) begin
        Instruction <= NOP_WORD;
        inst_valid <= 1'b0;
        fetch_fault <= '0;
      end else if (fetch_en) begin
        // faulting fetches still report valid so the pipeline can decode the fault
        Instruction <= (misaligned | out_of_range) ? NOP_WORD : mem[Address[IDX_W+1:2]];
        inst_valid <= 1'b1;
        fetch_fault <= {out_of_range, misaligned};
      end
    end
  end
  always_ff @(posedge clk) if (we) mem[ptr] <= wdata;
endmodule
